// File: rtl/stack_ptr_unit.sv
// Stack-pointer unit: keeps an occupancy count for a stack region of
// configurable base, depth and growth direction, and derives the next-free
// address (sp) and most-recent-entry address (top_addr) from it.
// Supports PUSH/POP, LOAD, ALLOC/FREE and a multi-cycle UNWIND with a
// busy/done handshake. Overflow/underflow are sticky until err_clr.
//
// Handshake: an UNWIND accepted in IDLE raises busy from the next cycle;
// while busy is high op is ignored (err_clr still acts). When the unwind
// ends, busy drops and done pulses for exactly one cycle, in the same cycle
// that count shows its final value. An UNWIND of zero entries never raises
// busy and pulses done on the next cycle.
module stack_ptr_unit #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] BASE      = '0,
    parameter int               DEPTH     = 256,
    parameter bit               GROW_DOWN = 1'b0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] top_addr,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    // Range checks use a width that can hold count+din without wrapping.
    localparam int               XW      = CW + WIDTH + 1;
    localparam logic [XW-1:0]    DEPTH_X = XW'(DEPTH);
    localparam logic [WIDTH-1:0] TOP_DN  = BASE + WIDTH'(DEPTH - 1);

    localparam logic [2:0] OP_PUSH   = 3'b001;
    localparam logic [2:0] OP_POP    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_ALLOC  = 3'b100;
    localparam logic [2:0] OP_FREE   = 3'b101;
    localparam logic [2:0] OP_UNWIND = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        UNW  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              done_q, done_d;
    logic              ovf_evt, unf_evt;
    logic [XW-1:0]     count_x, din_x, alloc_x;

    assign count_x = XW'(count_q);
    assign din_x   = XW'(din);
    assign alloc_x = count_x + din_x;

    // Next-state, next-count and error-event decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (state_q)
            IDLE: begin
                case (op)
                    OP_PUSH: begin
                        if (count_x == DEPTH_X) ovf_evt = 1'b1;
                        else                    count_d = count_q + CW'(1);
                    end
                    OP_POP: begin
                        if (count_q == '0) unf_evt = 1'b1;
                        else               count_d = count_q - CW'(1);
                    end
                    OP_LOAD: begin
                        if (din_x > DEPTH_X) ovf_evt = 1'b1;
                        else                 count_d = CW'(din);
                    end
                    OP_ALLOC: begin
                        if (alloc_x > DEPTH_X) ovf_evt = 1'b1;
                        else                   count_d = CW'(alloc_x);
                    end
                    OP_FREE: begin
                        if (din_x > count_x) unf_evt = 1'b1;
                        else                 count_d = CW'(count_x - din_x);
                    end
                    OP_UNWIND: begin
                        if (din == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d   = din;
                            state_d = UNW;
                        end
                    end
                    default: ;
                endcase
            end
            UNW: begin
                // remaining is always non-zero while in UNW.
                if (count_q == '0) begin
                    unf_evt = 1'b1;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                    rem_d   = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new error event wins over a simultaneous clear.
        ovf_d = (ovf_q & ~err_clr) | ovf_evt;
        unf_d = (unf_q & ~err_clr) | unf_evt;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
        end
    end

    // Address and status outputs derived from the registered count.
    always_comb begin
        if (GROW_DOWN) sp = TOP_DN - WIDTH'(count_q);
        else           sp = BASE + WIDTH'(count_q);
        if (count_q == '0)  top_addr = sp;
        else if (GROW_DOWN) top_addr = sp + WIDTH'(1);
        else                top_addr = sp - WIDTH'(1);
    end

    assign count     = count_q;
    assign full      = (count_x == DEPTH_X);
    assign empty     = (count_q == '0);
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign busy      = (state_q == UNW);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Bench for stack_ptr_unit: one grow-up and one grow-down instance share
// stimulus; a behavioural model is compared every cycle, and directed steps
// carry hand-computed literal expectations.
module tb_stack_ptr_unit;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ALLOC = 3'b100;
    localparam logic [2:0] OP_FREE  = 3'b101;
    localparam logic [2:0] OP_UNW   = 3'b110;
    localparam logic [2:0] OP_NOP7  = 3'b111;
    localparam int         DEPTH    = 4;
    localparam int         BASE     = 'h0100;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = OP_NOP;
    logic [15:0] din = '0;
    logic        err_clr = 1'b0;
    logic        check_en = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] u_sp, u_top, d_sp, d_top;
    logic [2:0]  u_count, d_count;
    logic        u_full, u_empty, u_ovf, u_unf, u_busy, u_done, u_st;
    logic        d_full, d_empty, d_ovf, d_unf, d_busy, d_done, d_st;

    stack_ptr_unit #(.WIDTH(16), .BASE(16'h0100), .DEPTH(DEPTH), .GROW_DOWN(1'b0)) u_up (
        .CLK(clk), .reset(rst_n), .op(op), .din(din), .err_clr(err_clr),
        .sp(u_sp), .top_addr(u_top), .count(u_count), .full(u_full), .empty(u_empty),
        .ovf(u_ovf), .unf(u_unf), .busy(u_busy), .done(u_done), .state_dbg(u_st)
    );

    stack_ptr_unit #(.WIDTH(16), .BASE(16'h0100), .DEPTH(DEPTH), .GROW_DOWN(1'b1)) u_dn (
        .CLK(clk), .reset(rst_n), .op(op), .din(din), .err_clr(err_clr),
        .sp(d_sp), .top_addr(d_top), .count(d_count), .full(d_full), .empty(d_empty),
        .ovf(d_ovf), .unf(d_unf), .busy(d_busy), .done(d_done), .state_dbg(d_st)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_count = 0;
    int m_rem   = 0;
    bit m_busy  = 0;
    bit m_done  = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;
    bit m_oe, m_ue;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_rem = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_oe = 0; m_ue = 0; m_done = 0;
            if (m_busy) begin
                if (m_count == 0) begin
                    m_ue = 1; m_busy = 0; m_done = 1;
                end else begin
                    m_count = m_count - 1;
                    m_rem   = m_rem - 1;
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                end
            end else begin
                case (op)
                    OP_PUSH:  if (m_count + 1 > DEPTH) m_oe = 1; else m_count = m_count + 1;
                    OP_POP:   if (m_count - 1 < 0) m_ue = 1; else m_count = m_count - 1;
                    OP_LOAD:  if (int'(din) > DEPTH) m_oe = 1; else m_count = int'(din);
                    OP_ALLOC: if (m_count + int'(din) > DEPTH) m_oe = 1; else m_count = m_count + int'(din);
                    OP_FREE:  if (int'(din) > m_count) m_ue = 1; else m_count = m_count - int'(din);
                    OP_UNW: begin
                        if (din == 0) m_done = 1;
                        else begin m_busy = 1; m_rem = int'(din); end
                    end
                    default: ;
                endcase
            end
            m_ovf = (m_ovf && !err_clr) || m_oe;
            m_unf = (m_unf && !err_clr) || m_ue;
        end
    end

    function automatic logic [15:0] exp_sp(input bit down);
        return down ? 16'(BASE + DEPTH - 1 - m_count) : 16'(BASE + m_count);
    endfunction

    function automatic logic [15:0] exp_top(input bit down);
        if (m_count == 0) return exp_sp(down);
        return down ? 16'(exp_sp(down) + 1) : 16'(exp_sp(down) - 1);
    endfunction

    task automatic cmp_inst(input string n, input bit down, input logic [15:0] sp_v,
                            input logic [15:0] top_v, input logic [2:0] cnt_v, input logic fl,
                            input logic em, input logic ov, input logic un, input logic bs,
                            input logic dn, input logic st);
        check({n, ".sp"},    32'(sp_v),  32'(exp_sp(down)));
        check({n, ".top"},   32'(top_v), 32'(exp_top(down)));
        check({n, ".count"}, 32'(cnt_v), 32'(m_count));
        check({n, ".full"},  32'(fl),    32'(m_count == DEPTH));
        check({n, ".empty"}, 32'(em),    32'(m_count == 0));
        check({n, ".ovf"},   32'(ov),    32'(m_ovf));
        check({n, ".unf"},   32'(un),    32'(m_unf));
        check({n, ".busy"},  32'(bs),    32'(m_busy));
        check({n, ".done"},  32'(dn),    32'(m_done));
        check({n, ".state"}, 32'(st),    32'(m_busy));
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            cmp_inst("up", 1'b0, u_sp, u_top, u_count, u_full, u_empty, u_ovf, u_unf, u_busy, u_done, u_st);
            cmp_inst("dn", 1'b1, d_sp, d_top, d_count, d_full, d_empty, d_ovf, d_unf, d_busy, d_done, d_st);
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [2:0] o, input logic [15:0] d, input logic c);
        @(negedge clk);
        op = o; din = d; err_clr = c;
        @(posedge clk);
        #1;
        op = OP_NOP; din = '0; err_clr = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst.count", 32'(u_count), 0);
        check("rst.empty", 32'(u_empty), 1);
        check("rst.busy",  32'(u_busy),  0);
        check("rst.done",  32'(u_done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        #1;
        check("t1.sp0",   32'(u_sp),    'h0100);
        check("t1.top0",  32'(u_top),   'h0100);
        check("t1.empty", 32'(u_empty), 1);
        check("t1.dsp0",  32'(d_sp),    'h0103);

        // 1: fill grow-up stack, then overflow
        for (int i = 0; i < 4; i++) do_op(OP_PUSH, 16'd0, 1'b0);
        check("t1.sp4",  32'(u_sp),   'h0104);
        check("t1.top4", 32'(u_top),  'h0103);
        check("t1.full", 32'(u_full), 1);
        do_op(OP_PUSH, 16'd0, 1'b0);
        check("t1.cnt5", 32'(u_count), 4);
        check("t1.ovf",  32'(u_ovf),   1);
        do_op(OP_NOP7, 16'd0, 1'b1);
        check("t1.clr",  32'(u_ovf),   0);

        // 2: grow-down addresses and underflow
        do_op(OP_LOAD, 16'd0, 1'b0);
        do_op(OP_PUSH, 16'd0, 1'b0);
        do_op(OP_PUSH, 16'd0, 1'b0);
        check("t2.dsp",  32'(d_sp),  'h0101);
        check("t2.dtop", 32'(d_top), 'h0102);
        for (int i = 0; i < 3; i++) do_op(OP_POP, 16'd0, 1'b0);
        check("t2.cnt",  32'(d_count), 0);
        check("t2.dsp0", 32'(d_sp),    'h0103);
        check("t2.unf",  32'(d_unf),   1);
        do_op(OP_NOP, 16'd0, 1'b1);
        check("t2.clr",  32'(d_unf),   0);

        // 3: bulk ops and range checks without wrap
        do_op(OP_LOAD, 16'd2, 1'b0);
        do_op(OP_ALLOC, 16'd3, 1'b0);
        check("t3.alloc.cnt", 32'(u_count), 2);
        check("t3.alloc.ovf", 32'(u_ovf),   1);
        do_op(OP_FREE, 16'd2, 1'b1);
        check("t3.free.cnt",  32'(u_count), 0);
        check("t3.free.emp",  32'(u_empty), 1);
        check("t3.free.clr",  32'(u_ovf),   0);
        do_op(OP_LOAD, 16'd5, 1'b0);
        check("t3.ld5.ovf",   32'(u_ovf),   1);
        check("t3.ld5.cnt",   32'(u_count), 0);
        do_op(OP_ALLOC, 16'hFFFF, 1'b1);
        check("t3.bigalloc.cnt", 32'(u_count), 0);
        check("t3.bigalloc.ovf", 32'(u_ovf),   1);
        do_op(OP_LOAD, 16'd4, 1'b1);
        check("t3.ld4.full",  32'(u_full),  1);
        do_op(OP_FREE, 16'hFFFF, 1'b0);
        check("t3.bigfree.unf", 32'(u_unf),   1);
        check("t3.bigfree.cnt", 32'(u_count), 4);
        do_op(OP_LOAD, 16'd3, 1'b1);
        do_op(OP_ALLOC, 16'd1, 1'b0);
        check("t3.alloc1.full", 32'(u_full), 1);
        check("t3.alloc1.ovf",  32'(u_ovf),  0);

        // 4: UNWIND 3 from 4, ops ignored while busy
        do_op(OP_UNW, 16'd3, 1'b0);
        check("t4.busy0", 32'(u_busy),  1);
        check("t4.cnt0",  32'(u_count), 4);
        do_op(OP_PUSH, 16'd0, 1'b0);
        check("t4.cnt1",  32'(u_count), 3);
        do_op(OP_LOAD, 16'd0, 1'b0);
        check("t4.cnt2",  32'(u_count), 2);
        check("t4.busy2", 32'(u_busy),  1);
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t4.cnt3",  32'(u_count), 1);
        check("t4.done",  32'(u_done),  1);
        check("t4.busy3", 32'(u_busy),  0);
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t4.done0", 32'(u_done),  0);

        // 5: UNWIND past empty, then UNWIND 0
        do_op(OP_LOAD, 16'd2, 1'b0);
        do_op(OP_UNW, 16'd5, 1'b0);
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t5.cnt1", 32'(u_count), 1);
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t5.cnt0", 32'(u_count), 0);
        check("t5.busy", 32'(u_busy),  1);
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t5.unf",  32'(u_unf),   1);
        check("t5.done", 32'(u_done),  1);
        check("t5.idle", 32'(u_busy),  0);
        do_op(OP_UNW, 16'd0, 1'b1);
        check("t5.z.done", 32'(u_done), 1);
        check("t5.z.busy", 32'(u_busy), 0);
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t5.z.done0", 32'(u_done), 0);

        // 6: reset mid-UNWIND, then set-wins on err_clr
        do_op(OP_LOAD, 16'd4, 1'b0);
        do_op(OP_UNW, 16'd3, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6.rst.cnt",  32'(u_count), 0);
        check("t6.rst.busy", 32'(u_busy),  0);
        check("t6.rst.done", 32'(u_done),  0);
        check("t6.rst.emp",  32'(u_empty), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(OP_NOP, 16'd0, 1'b0);
        check("t6.nodone", 32'(u_done), 0);
        do_op(OP_POP, 16'd0, 1'b1);
        check("t6.setwins", 32'(u_unf), 1);
        check("t6.cnt",     32'(u_count), 0);

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
